// File: rtl/stepdown_corestate_pkg.sv
// ------------------------------------------------------------------------
// stepdown_corestate_pkg: core-state codes, sequencer FSM states, code check
// Revision: 1.0
// ------------------------------------------------------------------------
`default_nettype none

package stepdown_corestate_pkg;

  typedef enum logic [2:0] {
    CODE_OFF       = 3'd0,
    CODE_SOFTSTART = 3'd1,
    CODE_BUCK      = 3'd2,
    CODE_SKIP      = 3'd3,
    CODE_DISCH     = 3'd4
  } code_e;

  typedef enum logic [3:0] {
    ST_OFF   = 4'd0,
    ST_DT    = 4'd1,
    ST_HS    = 4'd2,
    ST_DT_HL = 4'd3,
    ST_LS    = 4'd4,
    ST_DT_LH = 4'd5,
    ST_SKIP  = 4'd6,
    ST_DISCH = 4'd7,
    ST_FAULT = 4'd8
  } fsm_e;

  function automatic logic code_illegal(input logic [2:0] code);
    return code > 3'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stepdown_deadtime_ctr.sv
// ------------------------------------------------------------------------
// stepdown_deadtime_ctr: loadable saturating down-counter, done on last cycle
// Revision: 1.0
// ------------------------------------------------------------------------
`default_nettype none

module stepdown_deadtime_ctr #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  output logic          done
);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // done marks the final cycle of the loaded interval so the owner can leave on this edge
  assign done = (cnt == DW'(1));

endmodule

`default_nettype wire

// File: rtl/stepdown_corestate_sequencer.sv
// ------------------------------------------------------------------------
// stepdown_corestate_sequencer: core-state handshake to dead-timed HS/LS gate PWM
// Revision: 1.0
// ------------------------------------------------------------------------
`default_nettype none

module stepdown_corestate_sequencer
  import stepdown_corestate_pkg::*;
#(
  parameter int DT_CYC  = 4,
  parameter int PER_CYC = 32,
  parameter int DW      = 8
) (
  input  logic          CELCLK,
  input  logic          CELRSTB,
  input  logic          CELV,
  input  logic          CELG,
  input  logic          SUB,
  input  logic          state_vld,
  input  logic [2:0]    state_code,
  input  logic [DW-1:0] duty,
  input  logic          fault_clr,
  output logic          state_rdy,
  output logic          hs_en,
  output logic          ls_en,
  output logic [2:0]    cur_state,
  output logic          fault
);

  localparam logic [DW-1:0] MAX_D  = DW'(PER_CYC - 2 * DT_CYC - 1);
  localparam logic [DW-1:0] LS_END = DW'(PER_CYC - DT_CYC);
  localparam logic [DW-1:0] DT_LEN = DW'(DT_CYC);

  fsm_e          st;
  logic [DW-1:0] pc;
  logic [DW-1:0] dval;
  logic [DW-1:0] ss;

  logic          accept;
  logic          illegal;
  logic [DW-1:0] pc_nxt;
  logic [DW-1:0] cd;
  logic [DW-1:0] d_new;
  logic          hs_end;
  logic          ls_end;
  logic          dt_load;
  logic          dt_done;
  logic          period_start;
  logic          unused_supply;

  assign unused_supply = CELV ^ CELG ^ SUB;

  always_comb begin
    accept  = state_vld & state_rdy;
    illegal = code_illegal(state_code);
    pc_nxt  = pc + 1'b1;
    cd      = (duty > MAX_D) ? MAX_D : duty;
    d_new   = cd;
    if (cur_state == CODE_SOFTSTART && ss < cd) begin
      d_new = ss;
    end
    hs_end  = (st == ST_HS) && (pc_nxt == dval);
    ls_end  = (st == ST_LS) && (pc_nxt == LS_END);
    dt_load = accept ? !illegal : (hs_end | ls_end);
    period_start = dt_done &&
                   ((st == ST_DT_LH) ||
                    (st == ST_DT && (cur_state == CODE_BUCK || cur_state == CODE_SOFTSTART)));
  end

  stepdown_deadtime_ctr #(
    .DW(DW)
  ) u_dt_ctr (
    .clk      (CELCLK),
    .rst_n    (CELRSTB),
    .load     (dt_load),
    .load_val (DT_LEN),
    .done     (dt_done)
  );

  always_ff @(posedge CELCLK or negedge CELRSTB) begin
    if (!CELRSTB) begin
      st        <= ST_OFF;
      hs_en     <= 1'b0;
      ls_en     <= 1'b0;
      state_rdy <= 1'b0;
      cur_state <= 3'd0;
      fault     <= 1'b0;
      pc        <= '0;
      dval      <= '0;
      ss        <= '0;
    end else if (accept) begin
      // Any active enable drops on the accepting edge, before the dead time starts
      hs_en     <= 1'b0;
      ls_en     <= 1'b0;
      state_rdy <= 1'b0;
      pc        <= '0;
      ss        <= '0;
      if (illegal) begin
        st    <= ST_FAULT;
        fault <= 1'b1;
      end else begin
        st        <= ST_DT;
        cur_state <= state_code;
      end
    end else if (period_start) begin
      pc        <= '0;
      dval      <= d_new;
      state_rdy <= 1'b1;
      if (cur_state == CODE_SOFTSTART && ss < cd) begin
        ss <= ss + 1'b1;
      end
      if (d_new != '0) begin
        st    <= ST_HS;
        hs_en <= 1'b1;
        ls_en <= 1'b0;
      end else begin
        st    <= ST_LS;
        hs_en <= 1'b0;
        ls_en <= 1'b1;
      end
    end else begin
      case (st)
        ST_OFF: state_rdy <= 1'b1;
        ST_DT: begin
          if (dt_done) begin
            state_rdy <= 1'b1;
            case (cur_state)
              CODE_DISCH: begin
                st    <= ST_DISCH;
                ls_en <= 1'b1;
              end
              CODE_SKIP: st <= ST_SKIP;
              default:   st <= ST_OFF;
            endcase
          end
        end
        ST_HS: begin
          pc        <= pc_nxt;
          state_rdy <= 1'b0;
          if (hs_end) begin
            st    <= ST_DT_HL;
            hs_en <= 1'b0;
          end
        end
        ST_DT_HL: begin
          pc <= pc_nxt;
          if (dt_done) begin
            st    <= ST_LS;
            ls_en <= 1'b1;
          end
        end
        ST_LS: begin
          pc        <= pc_nxt;
          state_rdy <= 1'b0;
          if (ls_end) begin
            st    <= ST_DT_LH;
            ls_en <= 1'b0;
          end
        end
        ST_DT_LH: pc <= pc_nxt;
        ST_SKIP: begin
          pc        <= '0;
          state_rdy <= 1'b1;
        end
        ST_DISCH: state_rdy <= 1'b1;
        ST_FAULT: begin
          if (fault_clr) begin
            st        <= ST_OFF;
            fault     <= 1'b0;
            state_rdy <= 1'b1;
          end
        end
        default: st <= ST_OFF;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stepdown_corestate_sequencer.sv
// ------------------------------------------------------------------------
// tb_stepdown_corestate_sequencer: directed bench with per-cycle reference model
// Revision: 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_stepdown_corestate_sequencer;

  localparam int DT   = 4;
  localparam int PER  = 32;
  localparam int DW   = 8;
  localparam int MAXD = PER - 2 * DT - 1;

  localparam int P_RST = 0, P_STATIC = 1, P_DEAD = 2, P_PWM = 3, P_FAULT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vld = 1'b0;
  logic          fclr = 1'b0;
  logic [2:0]    code = 3'd0;
  logic [DW-1:0] duty = '0;
  logic          rdy, hs, ls, flt;
  logic [2:0]    cur;

  always #5 clk = ~clk;

  stepdown_corestate_sequencer #(.DT_CYC(DT), .PER_CYC(PER), .DW(DW)) dut (
    .CELCLK(clk), .CELRSTB(rst_n), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .state_vld(vld), .state_code(code), .duty(duty), .fault_clr(fclr),
    .state_rdy(rdy), .hs_en(hs), .ls_en(ls), .cur_state(cur), .fault(flt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode timeline expressed as cycles since PWM entry
  typedef struct {
    int phase; int mode; int dead; int k; int d;
    logic [2:0] cur; logic fault; logic rdy; logic hs; logic ls;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r.phase = P_RST; r.mode = 0; r.dead = 0; r.k = 0; r.d = 0;
    r.cur = 3'd0; r.fault = 1'b0; r.rdy = 1'b0; r.hs = 1'b0; r.ls = 1'b0;
    return r;
  endfunction

  function automatic model_t model_next(input model_t m, input logic v, input logic [2:0] c,
                                        input logic clr, input int dty);
    model_t n;
    int pos, cd, p;
    n = m;
    if (v && m.rdy) begin
      if (c > 3'd4) begin
        n.phase = P_FAULT; n.fault = 1'b1;
      end else begin
        n.cur = c; n.mode = int'(c); n.phase = P_DEAD; n.dead = 1;
      end
    end else begin
      case (m.phase)
        P_RST:   begin n.phase = P_STATIC; n.mode = 0; end
        P_DEAD: begin
          if (m.dead < DT) n.dead = m.dead + 1;
          else if (m.mode == 1 || m.mode == 2) begin n.phase = P_PWM; n.k = 0; end
          else n.phase = P_STATIC;
        end
        P_PWM:   n.k = m.k + 1;
        P_FAULT: if (clr) begin n.phase = P_STATIC; n.mode = 0; n.fault = 1'b0; end
        default: ;
      endcase
    end
    if (n.phase == P_PWM && n.k % PER == 0) begin
      cd = (dty > MAXD) ? MAXD : dty;
      p  = n.k / PER;
      n.d = (n.mode == 2) ? cd : ((p < cd) ? p : cd);
    end
    n.rdy = 1'b0; n.hs = 1'b0; n.ls = 1'b0;
    if (n.phase == P_STATIC) begin
      n.rdy = 1'b1; n.ls = (n.mode == 4);
    end else if (n.phase == P_PWM) begin
      pos = n.k % PER;
      n.rdy = (pos == 0);
      n.hs = (pos < n.d);
      n.ls = (pos >= ((n.d == 0) ? 0 : n.d + DT)) && (pos < PER - DT);
    end
    return n;
  endfunction

  model_t m;

  initial begin
    m = model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m = model_reset();
      else m = model_next(m, vld, code, fclr, int'(duty));
    end
  end

  int hs_w[$];
  int ls_w[$];
  int hs_run = 0, ls_run = 0, since_hs = 100, since_ls = 100;
  logic hs_prev = 1'b0, ls_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      check("cycle{rdy,hs,ls,cur,fault}", {rdy, hs, ls, cur, flt},
            {m.rdy, m.hs, m.ls, m.cur, m.fault});
      check("overlap", {31'd0, hs & ls}, 32'd0);
      if (!rst_n) begin
        since_hs = 100; since_ls = 100;
      end else begin
        if (hs && !hs_prev) check("gap_ls_to_hs", {31'd0, since_ls >= DT}, 32'd1);
        if (ls && !ls_prev) check("gap_hs_to_ls", {31'd0, since_hs >= DT}, 32'd1);
        since_hs = hs ? 0 : since_hs + 1;
        since_ls = ls ? 0 : since_ls + 1;
      end
      if (hs) hs_run++; else if (hs_run > 0) begin hs_w.push_back(hs_run); hs_run = 0; end
      if (ls) ls_run++; else if (ls_run > 0) begin ls_w.push_back(ls_run); ls_run = 0; end
      hs_prev = hs; ls_prev = ls;
    end
  end

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic acc_hs;

  task automatic send(input logic [2:0] c);
    int b;
    b = 0;
    code = c;
    vld = 1'b1;
    while (!rdy && b < 300) begin step(); b++; end
    if (b >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL handshake: state_rdy never rose, got 0 expected 1");
    end
    acc_hs = hs;
    step();
    vld = 1'b0;
  endtask

  task automatic count_dead(output int n);
    n = 0;
    while (!hs && !ls && n < 100) begin n++; step(); end
  endtask

  task automatic clear_w();
    hs_w.delete();
    ls_w.delete();
  endtask

  int nd;
  int b;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    check("reset_outs", {rdy, hs, ls, cur, flt}, 32'd0);
    rst_n = 1'b1;
    check("rdy_before_first_edge", rdy, 1'b0);
    step();
    check("rdy_after_release", rdy, 1'b1);

    // BUCK, duty 10
    duty = 8'd10;
    send(3'd2);
    count_dead(nd);
    check("buck_entry_dead", nd, 4);
    check("buck_first_hs", hs, 1'b1);
    check("buck_rdy_period_start", rdy, 1'b1);
    step();
    check("buck_rdy_dropped", rdy, 1'b0);
    clear_w();
    repeat (3 * PER) step();
    check("buck_hs_w0", qat(hs_w, 0), 10);
    check("buck_hs_w1", qat(hs_w, 1), 10);
    check("buck_ls_w0", qat(ls_w, 0), 14);

    // SOFTSTART, duty 3
    duty = 8'd3;
    send(3'd1);
    step();
    clear_w();
    repeat (7 * PER) step();
    check("ss_hs_w0", qat(hs_w, 0), 1);
    check("ss_hs_w1", qat(hs_w, 1), 2);
    check("ss_hs_w2", qat(hs_w, 2), 3);
    check("ss_hs_w3", qat(hs_w, 3), 3);
    check("ss_hs_w4", qat(hs_w, 4), 3);
    check("ss_ls_w0", qat(ls_w, 0), 28);
    check("ss_ls_w1", qat(ls_w, 1), 23);

    // BUCK with duty clamp
    duty = 8'd255;
    send(3'd2);
    step();
    clear_w();
    repeat (2 * PER + 8) step();
    check("clamp_hs_w0", qat(hs_w, 0), 23);
    check("clamp_ls_w0", qat(ls_w, 0), 1);

    // DISCH requested during BUCK high-side phase
    duty = 8'd10;
    send(3'd4);
    check("disch_acc_during_hs", acc_hs, 1'b1);
    check("disch_hs_drop", hs, 1'b0);
    count_dead(nd);
    check("disch_entry_dead", nd, 4);
    check("disch_ls_on", ls, 1'b1);
    check("disch_cur", cur, 3'd4);
    fclr = 1'b1;
    step();
    fclr = 1'b0;
    repeat (5) step();
    check("clr_ignored_outside_fault", {flt, ls}, 2'b01);

    // Illegal code and recovery
    send(3'd6);
    check("fault_set", {flt, hs, ls, rdy}, 4'b1000);
    check("fault_cur_kept", cur, 3'd4);
    repeat (5) step();
    check("fault_held", flt, 1'b1);
    fclr = 1'b1;
    step();
    fclr = 1'b0;
    check("fault_cleared", {flt, rdy}, 2'b01);

    // SKIP then OFF
    send(3'd3);
    repeat (10) step();
    check("skip_cur", cur, 3'd3);
    send(3'd0);
    repeat (10) step();

    // Asynchronous reset during low-side phase
    send(3'd2);
    b = 0;
    while (!ls && b < 100) begin step(); b++; end
    step();
    step();
    check("pre_reset_ls", ls, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_drop", {hs, ls, rdy}, 3'b000);
    step();
    step();
    rst_n = 1'b1;
    check("post_reset_outs", {rdy, hs, ls, cur, flt}, 32'd0);
    step();
    check("post_reset_rdy", rdy, 1'b1);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
